// File: rtl/prv_trap_ctrl_if.sv
// Exception/return/interrupt bundle between the hazard unit, the trap
// controller and the machine-mode CSR file.
interface prv_trap_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    // Pipeline / CSR side toward the controller
    logic [8:0]      exc_flags;
    logic            ret;
    logic            pipe_clear;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] badaddr;
    logic [2:0]      irq;
    logic            mie_global;
    logic [2:0]      mie_mask;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc_r;

    // Controller results
    logic [XLEN-1:0] priv_pc;
    logic            insert_pc;
    logic            intr;
    logic            trap_we;
    logic            mret_we;
    logic [XLEN-1:0] mcause_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mtval_o;

    // Driver of the request signals (hazard unit / CSR file)
    modport master (
        output exc_flags, ret, pipe_clear, epc, badaddr, irq,
        output mie_global, mie_mask, mtvec, mepc_r,
        input  priv_pc, insert_pc, intr, trap_we, mret_we,
        input  mcause_o, mepc_o, mtval_o
    );

    // The trap controller itself
    modport slave (
        input  exc_flags, ret, pipe_clear, epc, badaddr, irq,
        input  mie_global, mie_mask, mtvec, mepc_r,
        output priv_pc, insert_pc, intr, trap_we, mret_we,
        output mcause_o, mepc_o, mtval_o
    );
endinterface

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap controller: prioritises synchronous exceptions, waits for
// the pipeline to drain on interrupts, handles mret, and issues one-cycle
// redirect/commit strobes with latched mcause/mepc/mtval values.
module prv_trap_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    prv_trap_ctrl_if.slave bus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIntWait = 2'd1;
    localparam logic [1:0] StTrap    = 2'd2;
    localparam logic [1:0] StRet     = 2'd3;

    localparam logic [XLEN-1:0] IntBit = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic            intr_q, intr_d;
    logic            insert_q, insert_d;
    logic            trap_we_q, trap_we_d;
    logic            mret_we_q, mret_we_d;
    logic [XLEN-1:0] priv_pc_q, priv_pc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mtval_q, mtval_d;

    logic            exc_any;
    logic [4:0]      exc_code;
    logic            exc_has_tval;
    logic [2:0]      irq_act;
    logic            irq_pending;
    logic [4:0]      int_code;
    logic [XLEN-1:0] vec_base;
    logic            vec_mode;

    assign exc_any     = |bus.exc_flags;
    assign irq_act     = bus.irq & bus.mie_mask;
    assign irq_pending = bus.mie_global & (|irq_act);
    assign vec_base    = {bus.mtvec[XLEN-1:2], 2'b00};
    assign vec_mode    = VECTORED_EN && (bus.mtvec[1:0] == 2'b01);

    // Synchronous exception priority encoder; breakpoint and ecall carry no mtval
    always_comb begin
        exc_code     = 5'd0;
        exc_has_tval = 1'b1;
        if (bus.exc_flags[0]) begin
            exc_code = 5'd1;
        end else if (bus.exc_flags[1]) begin
            exc_code = 5'd0;
        end else if (bus.exc_flags[2]) begin
            exc_code = 5'd2;
        end else if (bus.exc_flags[3]) begin
            exc_code     = 5'd3;
            exc_has_tval = 1'b0;
        end else if (bus.exc_flags[4]) begin
            exc_code     = 5'd11;
            exc_has_tval = 1'b0;
        end else if (bus.exc_flags[5]) begin
            exc_code = 5'd4;
        end else if (bus.exc_flags[6]) begin
            exc_code = 5'd5;
        end else if (bus.exc_flags[7]) begin
            exc_code = 5'd6;
        end else if (bus.exc_flags[8]) begin
            exc_code = 5'd7;
        end
    end

    // Interrupt priority: external > software > timer
    always_comb begin
        int_code = 5'd7;
        if (irq_act[2]) begin
            int_code = 5'd11;
        end else if (irq_act[0]) begin
            int_code = 5'd3;
        end
    end

    // Next-state and registered-output values; strobes default to a single cycle
    always_comb begin
        state_d   = state_q;
        intr_d    = intr_q;
        insert_d  = 1'b0;
        trap_we_d = 1'b0;
        mret_we_d = 1'b0;
        priv_pc_d = priv_pc_q;
        mcause_d  = mcause_q;
        mepc_d    = mepc_q;
        mtval_d   = mtval_q;
        case (state_q)
            StIdle, StIntWait: begin
                if (exc_any) begin
                    state_d   = StTrap;
                    intr_d    = 1'b0;
                    insert_d  = 1'b1;
                    trap_we_d = 1'b1;
                    priv_pc_d = vec_base;
                    mcause_d  = XLEN'(exc_code);
                    mepc_d    = bus.epc;
                    mtval_d   = exc_has_tval ? bus.badaddr : '0;
                end else if (state_q == StIdle) begin
                    if (bus.ret) begin
                        state_d   = StRet;
                        insert_d  = 1'b1;
                        mret_we_d = 1'b1;
                        priv_pc_d = bus.mepc_r;
                    end else if (irq_pending) begin
                        state_d = StIntWait;
                        intr_d  = 1'b1;
                    end
                end else if (!irq_pending) begin
                    // Interrupt withdrawn before the pipeline drained
                    state_d = StIdle;
                    intr_d  = 1'b0;
                end else if (bus.pipe_clear) begin
                    state_d   = StTrap;
                    intr_d    = 1'b0;
                    insert_d  = 1'b1;
                    trap_we_d = 1'b1;
                    priv_pc_d = vec_mode ? (vec_base + XLEN'({int_code, 2'b00})) : vec_base;
                    mcause_d  = IntBit | XLEN'(int_code);
                    mepc_d    = bus.epc;
                    mtval_d   = '0;
                end
            end
            default: begin
                // StTrap and StRet last exactly one cycle
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            intr_q    <= 1'b0;
            insert_q  <= 1'b0;
            trap_we_q <= 1'b0;
            mret_we_q <= 1'b0;
            priv_pc_q <= '0;
            mcause_q  <= '0;
            mepc_q    <= '0;
            mtval_q   <= '0;
        end else begin
            state_q   <= state_d;
            intr_q    <= intr_d;
            insert_q  <= insert_d;
            trap_we_q <= trap_we_d;
            mret_we_q <= mret_we_d;
            priv_pc_q <= priv_pc_d;
            mcause_q  <= mcause_d;
            mepc_q    <= mepc_d;
            mtval_q   <= mtval_d;
        end
    end

    // Strobes are masked by RST so a reset during the commit cycle cancels it
    assign bus.insert_pc = insert_q & ~RST;
    assign bus.trap_we   = trap_we_q & ~RST;
    assign bus.mret_we   = mret_we_q & ~RST;
    assign bus.intr      = intr_q;
    assign bus.priv_pc   = priv_pc_q;
    assign bus.mcause_o  = mcause_q;
    assign bus.mepc_o    = mepc_q;
    assign bus.mtval_o   = mtval_q;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Directed self-checking bench for prv_trap_ctrl.
module tb_prv_trap_ctrl;

    logic clk;
    logic rst;
    int   nerr;
    int   nchk;

    prv_trap_ctrl_if #(.XLEN(32)) bus ();

    prv_trap_ctrl #(
        .XLEN        (32),
        .VECTORED_EN (1'b1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        rst  = 1'b1;
        bus.exc_flags  = 9'h000;
        bus.ret        = 1'b0;
        bus.pipe_clear = 1'b0;
        bus.epc        = 32'h0;
        bus.badaddr    = 32'h0;
        bus.irq        = 3'b000;
        bus.mie_global = 1'b0;
        bus.mie_mask   = 3'b000;
        bus.mtvec      = 32'h0;
        bus.mepc_r     = 32'h0;
        tick();
        tick();
        chk("rst_insert", bus.insert_pc, 0);
        chk("rst_intr", bus.intr, 0);
        chk("rst_trap_we", bus.trap_we, 0);
        chk("rst_mret_we", bus.mret_we, 0);
        chk("rst_priv_pc", bus.priv_pc, 0);
        chk("rst_mcause", bus.mcause_o, 0);
        chk("rst_mepc", bus.mepc_o, 0);
        chk("rst_mtval", bus.mtval_o, 0);
        rst = 1'b0;
        tick();

        // Illegal instruction, held through the trap cycle
        bus.mtvec     = 32'h8000_0000;
        bus.exc_flags = 9'h004;
        bus.epc       = 32'h0000_0100;
        bus.badaddr   = 32'hDEAD_BEEF;
        tick();
        chk("ill_insert", bus.insert_pc, 1);
        chk("ill_trap_we", bus.trap_we, 1);
        chk("ill_mret_we", bus.mret_we, 0);
        chk("ill_priv_pc", bus.priv_pc, 32'h8000_0000);
        chk("ill_mcause", bus.mcause_o, 2);
        chk("ill_mepc", bus.mepc_o, 32'h100);
        chk("ill_mtval", bus.mtval_o, 32'hDEAD_BEEF);
        tick();
        chk("ill_one_cycle", bus.insert_pc, 0);
        chk("ill_we_one_cycle", bus.trap_we, 0);
        chk("ill_hold_mcause", bus.mcause_o, 2);
        bus.exc_flags = 9'h000;
        tick();
        chk("ill_idle", bus.insert_pc, 0);

        // All flags: fault_insn wins
        bus.exc_flags = 9'h1FF;
        bus.epc       = 32'h0000_0104;
        bus.badaddr   = 32'h1111_1111;
        tick();
        chk("all_mcause", bus.mcause_o, 1);
        chk("all_mtval", bus.mtval_o, 32'h1111_1111);
        chk("all_mepc", bus.mepc_o, 32'h104);
        bus.exc_flags = 9'h000;
        tick();

        // Breakpoint + env: breakpoint wins, no mtval
        bus.exc_flags = 9'h018;
        tick();
        chk("bp_mcause", bus.mcause_o, 3);
        chk("bp_mtval", bus.mtval_o, 0);
        bus.exc_flags = 9'h000;
        tick();

        // Env + mal_l: env wins, no mtval
        bus.exc_flags = 9'h030;
        tick();
        chk("env_mcause", bus.mcause_o, 11);
        chk("env_mtval", bus.mtval_o, 0);
        bus.exc_flags = 9'h000;
        tick();

        // fault_s alone: lowest priority, carries mtval
        bus.exc_flags = 9'h100;
        bus.badaddr   = 32'h0000_0FF0;
        tick();
        chk("fs_mcause", bus.mcause_o, 7);
        chk("fs_mtval", bus.mtval_o, 32'h0FF0);
        bus.exc_flags = 9'h000;
        tick();

        // Interrupts pending but globally disabled
        bus.irq      = 3'b111;
        bus.mie_mask = 3'b111;
        tick();
        chk("gdis_intr", bus.intr, 0);

        // All interrupts, vectored, pipe_clear four cycles later
        bus.mie_global = 1'b1;
        bus.mtvec      = 32'h8000_0001;
        bus.epc        = 32'h0000_0300;
        bus.badaddr    = 32'h5555_5555;
        tick();
        chk("int_intr_c1", bus.intr, 1);
        chk("int_noins_c1", bus.insert_pc, 0);
        tick();
        chk("int_intr_c2", bus.intr, 1);
        tick();
        chk("int_intr_c3", bus.intr, 1);
        tick();
        chk("int_intr_c4", bus.intr, 1);
        bus.pipe_clear = 1'b1;
        tick();
        chk("int_intr_drop", bus.intr, 0);
        chk("int_insert", bus.insert_pc, 1);
        chk("int_trap_we", bus.trap_we, 1);
        chk("int_mcause", bus.mcause_o, 32'h8000_000B);
        chk("int_priv_pc", bus.priv_pc, 32'h8000_002C);
        chk("int_mtval", bus.mtval_o, 0);
        chk("int_mepc", bus.mepc_o, 32'h300);
        bus.pipe_clear = 1'b0;
        bus.irq        = 3'b000;
        tick();
        chk("int_one_cycle", bus.insert_pc, 0);

        // Soft + timer: soft wins, vectored to base + 12
        bus.irq = 3'b011;
        tick();
        bus.pipe_clear = 1'b1;
        tick();
        chk("soft_mcause", bus.mcause_o, 32'h8000_0003);
        chk("soft_priv_pc", bus.priv_pc, 32'h8000_000C);
        bus.pipe_clear = 1'b0;
        bus.irq        = 3'b000;
        tick();

        // Timer only, direct mode: base address, no offset
        bus.mtvec    = 32'h4000_0000;
        bus.irq      = 3'b111;
        bus.mie_mask = 3'b010;
        tick();
        bus.pipe_clear = 1'b1;
        tick();
        chk("tmr_mcause", bus.mcause_o, 32'h8000_0007);
        chk("tmr_priv_pc", bus.priv_pc, 32'h4000_0000);
        bus.pipe_clear = 1'b0;
        bus.irq        = 3'b000;
        tick();

        // Interrupt withdrawn before pipe_clear
        bus.irq      = 3'b001;
        bus.mie_mask = 3'b001;
        tick();
        chk("wd_intr_up", bus.intr, 1);
        bus.irq = 3'b000;
        tick();
        chk("wd_intr_down", bus.intr, 0);
        chk("wd_noins", bus.insert_pc, 0);
        chk("wd_notrap", bus.trap_we, 0);
        bus.pipe_clear = 1'b1;
        tick();
        chk("wd_noins2", bus.insert_pc, 0);
        chk("wd_notrap2", bus.trap_we, 0);
        bus.pipe_clear = 1'b0;

        // ret together with mal_l: exception wins
        bus.ret       = 1'b1;
        bus.exc_flags = 9'h020;
        bus.epc       = 32'h0000_0400;
        bus.badaddr   = 32'h0000_0044;
        bus.mtvec     = 32'h8000_0000;
        tick();
        chk("rx_mcause", bus.mcause_o, 4);
        chk("rx_mret_we", bus.mret_we, 0);
        chk("rx_trap_we", bus.trap_we, 1);
        chk("rx_mtval", bus.mtval_o, 32'h44);
        bus.ret       = 1'b0;
        bus.exc_flags = 9'h000;
        tick();
        chk("rx_mret_after", bus.mret_we, 0);

        // mret alone
        bus.ret    = 1'b1;
        bus.mepc_r = 32'h0000_0200;
        tick();
        chk("ret_insert", bus.insert_pc, 1);
        chk("ret_mret_we", bus.mret_we, 1);
        chk("ret_trap_we", bus.trap_we, 0);
        chk("ret_priv_pc", bus.priv_pc, 32'h200);
        bus.ret = 1'b0;
        tick();
        chk("ret_one_cycle", bus.mret_we, 0);
        chk("ret_ins_one_cycle", bus.insert_pc, 0);

        // Reset during the trap cycle cancels the commit
        bus.exc_flags = 9'h004;
        bus.epc       = 32'h0000_0500;
        tick();
        bus.exc_flags = 9'h000;
        rst           = 1'b1;
        #1;
        chk("rsttrap_insert", bus.insert_pc, 0);
        chk("rsttrap_trap_we", bus.trap_we, 0);
        tick();
        rst = 1'b0;
        chk("rsttrap_priv_pc", bus.priv_pc, 0);
        chk("rsttrap_mcause", bus.mcause_o, 0);
        chk("rsttrap_mepc", bus.mepc_o, 0);
        chk("rsttrap_mtval", bus.mtval_o, 0);
        chk("rsttrap_intr", bus.intr, 0);
        chk("rsttrap_ins2", bus.insert_pc, 0);

        // Back in IDLE: a fresh mal_insn traps normally
        bus.exc_flags = 9'h002;
        bus.epc       = 32'h0000_0600;
        tick();
        chk("post_insert", bus.insert_pc, 1);
        chk("post_mcause", bus.mcause_o, 0);
        chk("post_mepc", bus.mepc_o, 32'h600);
        bus.exc_flags = 9'h000;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
